// File: rtl/data_ld_store.sv
// data_ld_store
// Drains the data-load beat stream (ds_empty_n / ds_read handshake) and writes
// each payload beat into a round-robin bank of input-feature SRAMs. Addresses
// run sequentially from cfg_base_addr. The bank rotates after cfg_bank_depth
// words. The beat count is tracked against cfg_words. Once cfg_words beats are
// written, the rest of the stream is absorbed until its last beat.
//
// Handshake: a beat transfers on a rising clk edge where ds_empty_n && ds_read.
// ds_read depends only on the FSM state (high in LOAD and DRAIN), never on
// ds_empty_n.
//
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   ld_start             one-cycle pulse, latches cfg_* (honoured only in IDLE)
//   cfg_words            expected payload beats (0 = drain only)
//   cfg_base_addr        first word address used in every bank
//   cfg_bank_depth       words per bank before rotating (0 treated as 1)
//   ds_empty_n/ds_read   upstream beat valid / beat accept
//   fifo_data_din        beat data
//   fifo_last_din        final beat of the DMA transfer
//   sram_wen/addr/wdata  registered SRAM write port (one-hot bank enable)
//   ld_busy              high in LOAD or DRAIN
//   ld_done              one-cycle completion pulse
//   err_short/err_long   sticky length errors, cleared by the next ld_start
//   beat_cnt             payload beats written in the current load
module data_ld_store #(
    parameter int TBITS     = 64,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_BITS = 10,
    parameter int CNT_BITS  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_start,
    input  logic [CNT_BITS-1:0]  cfg_words,
    input  logic [ADDR_BITS-1:0] cfg_base_addr,
    input  logic [ADDR_BITS-1:0] cfg_bank_depth,
    input  logic                 ds_empty_n,
    output logic                 ds_read,
    input  logic [TBITS-1:0]     fifo_data_din,
    input  logic                 fifo_last_din,
    output logic [NUM_BANKS-1:0] sram_wen,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [TBITS-1:0]     sram_wdata,
    output logic                 ld_busy,
    output logic                 ld_done,
    output logic                 err_short,
    output logic                 err_long,
    output logic [CNT_BITS-1:0]  beat_cnt
);

    localparam int BP_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [BP_BITS-1:0] BP_LAST = BP_BITS'(NUM_BANKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_BITS-1:0]  r_cfg_words;
    logic [ADDR_BITS-1:0] r_cfg_base;
    logic [ADDR_BITS-1:0] r_cfg_depth;
    logic [ADDR_BITS-1:0] r_addr;
    logic [BP_BITS-1:0]   r_bank_ptr;
    logic [NUM_BANKS-1:0] r_sram_wen;
    logic [ADDR_BITS-1:0] r_sram_addr;
    logic [TBITS-1:0]     r_sram_wdata;
    logic                 r_ld_done;
    logic                 r_err_short;
    logic                 r_err_long;
    logic [CNT_BITS-1:0]  r_beat_cnt;

    logic                 w_busy;
    logic                 w_accept;
    logic [ADDR_BITS-1:0] w_wrap_addr;
    logic [CNT_BITS-1:0]  w_cnt_inc;
    logic [NUM_BANKS-1:0] w_bank_onehot;

    assign w_busy        = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign w_accept      = ds_empty_n && w_busy;
    // Last word of the current bank; the sum wraps modulo 2^ADDR_BITS.
    assign w_wrap_addr   = r_cfg_base + r_cfg_depth - ADDR_BITS'(1);
    assign w_cnt_inc     = r_beat_cnt + CNT_BITS'(1);
    assign w_bank_onehot = NUM_BANKS'(1) << r_bank_ptr;

    assign ds_read    = w_busy;
    assign ld_busy    = w_busy;
    assign sram_wen   = r_sram_wen;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign ld_done    = r_ld_done;
    assign err_short  = r_err_short;
    assign err_long   = r_err_long;
    assign beat_cnt   = r_beat_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cfg_words  <= '0;
            r_cfg_base   <= '0;
            r_cfg_depth  <= '0;
            r_addr       <= '0;
            r_bank_ptr   <= '0;
            r_sram_wen   <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_ld_done    <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            r_beat_cnt   <= '0;
        end else begin
            // Write enable and done are single-cycle strobes.
            r_sram_wen <= '0;
            r_ld_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ld_start) begin
                        r_cfg_words <= cfg_words;
                        r_cfg_base  <= cfg_base_addr;
                        r_cfg_depth <= (cfg_bank_depth == '0) ? ADDR_BITS'(1) : cfg_bank_depth;
                        r_addr      <= cfg_base_addr;
                        r_bank_ptr  <= '0;
                        r_beat_cnt  <= '0;
                        r_err_short <= 1'b0;
                        r_err_long  <= 1'b0;
                        // A zero-length load has no payload: go straight to absorbing.
                        r_state     <= (cfg_words == '0) ? S_DRAIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_sram_wen   <= w_bank_onehot;
                        r_sram_addr  <= r_addr;
                        r_sram_wdata <= fifo_data_din;
                        r_beat_cnt   <= w_cnt_inc;
                        if (r_addr == w_wrap_addr) begin
                            r_addr     <= r_cfg_base;
                            r_bank_ptr <= (r_bank_ptr == BP_LAST) ? '0 : r_bank_ptr + BP_BITS'(1);
                        end else begin
                            r_addr <= r_addr + ADDR_BITS'(1);
                        end
                        if (fifo_last_din) begin
                            // The early last beat is still written, then flagged.
                            if (w_cnt_inc < r_cfg_words) begin
                                r_err_short <= 1'b1;
                            end
                            r_ld_done <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (w_cnt_inc == r_cfg_words) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Surplus beats are consumed but never reach the SRAMs.
                    if (w_accept) begin
                        r_err_long <= 1'b1;
                        if (fifo_last_din) begin
                            r_ld_done <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ld_store.sv
// tb_data_ld_store
// Directed bench for data_ld_store. A beat-level model predicts every output
// once per cycle. For beat k of a load, the model places the write in bank
// (k / depth) % NUM_BANKS at address base + k % depth. It compares the model
// against the DUT on each falling edge. Hand-written write lists and literal
// counter/flag values pin each scenario.
module tb_data_ld_store;

    localparam int TBITS     = 64;
    localparam int NUM_BANKS = 4;
    localparam int ADDR_BITS = 10;
    localparam int CNT_BITS  = 15;
    localparam int WR_W      = NUM_BANKS + ADDR_BITS + TBITS;

    logic                 clk;
    logic                 reset;
    logic                 ld_start;
    logic [CNT_BITS-1:0]  cfg_words;
    logic [ADDR_BITS-1:0] cfg_base_addr;
    logic [ADDR_BITS-1:0] cfg_bank_depth;
    logic                 ds_empty_n;
    logic                 ds_read;
    logic [TBITS-1:0]     fifo_data_din;
    logic                 fifo_last_din;
    logic [NUM_BANKS-1:0] sram_wen;
    logic [ADDR_BITS-1:0] sram_addr;
    logic [TBITS-1:0]     sram_wdata;
    logic                 ld_busy;
    logic                 ld_done;
    logic                 err_short;
    logic                 err_long;
    logic [CNT_BITS-1:0]  beat_cnt;

    data_ld_store #(
        .TBITS(TBITS), .NUM_BANKS(NUM_BANKS), .ADDR_BITS(ADDR_BITS), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk), .reset(reset), .ld_start(ld_start),
        .cfg_words(cfg_words), .cfg_base_addr(cfg_base_addr), .cfg_bank_depth(cfg_bank_depth),
        .ds_empty_n(ds_empty_n), .ds_read(ds_read),
        .fifo_data_din(fifo_data_din), .fifo_last_din(fifo_last_din),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .ld_busy(ld_busy), .ld_done(ld_done),
        .err_short(err_short), .err_long(err_long), .beat_cnt(beat_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_done_seen = 0;
    logic [WR_W-1:0] exp_q[$];
    logic [WR_W-1:0] got_q[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- beat-level model ----------------
    bit                   m_valid = 1'b0;
    bit                   m_busy  = 1'b0;
    bit                   m_done  = 1'b0;
    int                   m_k     = 0;
    int                   m_words = 0;
    int                   m_base  = 0;
    int                   m_depth = 1;
    logic [NUM_BANKS-1:0] e_wen   = '0;
    logic [ADDR_BITS-1:0] e_addr  = '0;
    logic [TBITS-1:0]     e_wdata = '0;
    logic                 e_done  = 1'b0;
    logic                 e_short = 1'b0;
    logic                 e_long  = 1'b0;
    logic [CNT_BITS-1:0]  e_cnt   = '0;

    always @(posedge clk) begin
        m_valid <= 1'b1;
        e_wen   <= '0;
        e_done  <= 1'b0;
        if (!reset) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_k     <= 0;
            e_addr  <= '0;
            e_wdata <= '0;
            e_short <= 1'b0;
            e_long  <= 1'b0;
            e_cnt   <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_busy) begin
            if (ld_start) begin
                m_words <= int'(cfg_words);
                m_base  <= int'(cfg_base_addr);
                m_depth <= (cfg_bank_depth == '0) ? 1 : int'(cfg_bank_depth);
                m_k     <= 0;
                e_cnt   <= '0;
                e_short <= 1'b0;
                e_long  <= 1'b0;
                m_busy  <= 1'b1;
            end
        end else if (ds_empty_n) begin
            if (m_k < m_words) begin
                e_wen   <= NUM_BANKS'(1) << ((m_k / m_depth) % NUM_BANKS);
                e_addr  <= ADDR_BITS'(m_base + (m_k % m_depth));
                e_wdata <= fifo_data_din;
                m_k     <= m_k + 1;
                e_cnt   <= CNT_BITS'(m_k + 1);
                if (fifo_last_din && (m_k + 1 < m_words)) e_short <= 1'b1;
            end else begin
                e_long <= 1'b1;
            end
            if (fifo_last_din) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                e_done <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("ds_read",   ds_read,   m_busy);
            check("ld_busy",   ld_busy,   m_busy);
            check("sram_wen",  sram_wen,  e_wen);
            check("ld_done",   ld_done,   e_done);
            check("err_short", err_short, e_short);
            check("err_long",  err_long,  e_long);
            check("beat_cnt",  beat_cnt,  e_cnt);
            if (e_wen != '0) begin
                check("sram_addr",  sram_addr,  e_addr);
                check("sram_wdata", sram_wdata, e_wdata);
            end
            if (sram_wen != '0) got_q.push_back({sram_wen, sram_addr, sram_wdata});
            if (ld_done === 1'b1) n_done_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic start_load(input int words, input int base, input int depth);
        cfg_words      = CNT_BITS'(words);
        cfg_base_addr  = ADDR_BITS'(base);
        cfg_bank_depth = ADDR_BITS'(depth);
        ld_start       = 1'b1;
        tick();
        ld_start       = 1'b0;
    endtask

    task automatic send_beat(input logic [TBITS-1:0] d, input bit last);
        ds_empty_n    = 1'b1;
        fifo_data_din = d;
        fifo_last_din = last;
        tick();
        ds_empty_n    = 1'b0;
        fifo_last_din = 1'b0;
    endtask

    task automatic begin_scenario();
        exp_q.delete();
        got_q.delete();
        n_done_seen = 0;
    endtask

    task automatic push_exp(input logic [NUM_BANKS-1:0] wen, input logic [ADDR_BITS-1:0] addr,
                            input logic [TBITS-1:0] d);
        exp_q.push_back({wen, addr, d});
    endtask

    task automatic check_writes(input string name);
        check({name, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, "_write"}, got_q[i], exp_q[i]);
    endtask

    // Eight beats, base 0x010, depth 4: bank 0 gets 0x010-0x013, bank 1 the same.
    task automatic exp_eight();
        for (int i = 0; i < 4; i++) push_exp(4'b0001, 10'h010 + 10'(i), 64'hA5A5_0000_0000_0000 + 64'(i));
        for (int i = 4; i < 8; i++) push_exp(4'b0010, 10'h010 + 10'(i - 4), 64'hA5A5_0000_0000_0000 + 64'(i));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset          = 1'b0;
        ld_start       = 1'b0;
        cfg_words      = '0;
        cfg_base_addr  = '0;
        cfg_bank_depth = '0;
        ds_empty_n     = 1'b0;
        fifo_data_din  = '0;
        fifo_last_din  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wen",   sram_wen,   4'b0);
        check("rst_addr",  sram_addr,  10'h0);
        check("rst_wdata", sram_wdata, 64'h0);
        check("rst_cnt",   beat_cnt,   15'd0);
        check("rst_read",  ds_read,    1'b0);
        check("rst_errs",  {err_short, err_long, ld_done, ld_busy}, 4'b0);
        tick();
        reset = 1'b1;
        gap(1);

        // 1: eight beats back-to-back, last on beat 8
        begin_scenario();
        exp_eight();
        start_load(8, 'h010, 4);
        for (int i = 0; i < 8; i++) send_beat(64'hA5A5_0000_0000_0000 + 64'(i), i == 7);
        gap(2);
        check_writes("s1");
        check("s1_done", n_done_seen, 1);
        check("s1_cnt", beat_cnt, 15'd8);
        check("s1_errs", {err_short, err_long}, 2'b00);

        // 2: same stream with valid toggling; a stray ld_start mid-load is ignored
        begin_scenario();
        exp_eight();
        start_load(8, 'h010, 4);
        for (int i = 0; i < 8; i++) begin
            send_beat(64'hA5A5_0000_0000_0000 + 64'(i), i == 7);
            if (i == 3) begin
                cfg_words     = 15'd2;
                cfg_base_addr = 10'h200;
                ld_start      = 1'b1;
                tick();
                ld_start      = 1'b0;
            end else begin
                gap(1);
            end
        end
        gap(2);
        check_writes("s2");
        check("s2_done", n_done_seen, 1);
        check("s2_cnt", beat_cnt, 15'd8);
        check("s2_errs", {err_short, err_long}, 2'b00);

        // 3: short transfer, 6 expected, last on beat 3
        begin_scenario();
        for (int i = 0; i < 3; i++) push_exp(4'b0001, 10'h020 + 10'(i), 64'h3000 + 64'(i));
        start_load(6, 'h020, 4);
        for (int i = 0; i < 3; i++) send_beat(64'h3000 + 64'(i), i == 2);
        gap(2);
        check_writes("s3");
        check("s3_done", n_done_seen, 1);
        check("s3_cnt", beat_cnt, 15'd3);
        check("s3_errs", {err_short, err_long}, 2'b10);

        // 4: long transfer, 4 expected, last on beat 7
        begin_scenario();
        push_exp(4'b0001, 10'h100, 64'h4000);
        push_exp(4'b0001, 10'h101, 64'h4001);
        push_exp(4'b0010, 10'h100, 64'h4002);
        push_exp(4'b0010, 10'h101, 64'h4003);
        start_load(4, 'h100, 2);
        for (int i = 0; i < 7; i++) send_beat(64'h4000 + 64'(i), i == 6);
        gap(2);
        check_writes("s4");
        check("s4_done", n_done_seen, 1);
        check("s4_cnt", beat_cnt, 15'd4);
        check("s4_errs", {err_short, err_long}, 2'b01);

        // 5: bank wrap at the top of the address space, depth 1
        begin_scenario();
        push_exp(4'b0001, 10'h3FF, 64'h5000);
        push_exp(4'b0010, 10'h3FF, 64'h5001);
        push_exp(4'b0100, 10'h3FF, 64'h5002);
        push_exp(4'b1000, 10'h3FF, 64'h5003);
        push_exp(4'b0001, 10'h3FF, 64'h5004);
        start_load(5, 'h3FF, 1);
        for (int i = 0; i < 5; i++) send_beat(64'h5000 + 64'(i), i == 4);
        gap(2);
        check_writes("s5");
        check("s5_done", n_done_seen, 1);
        check("s5_cnt", beat_cnt, 15'd5);
        check("s5_errs", {err_short, err_long}, 2'b00);

        // 5b: zero-length load, the only beat is surplus
        begin_scenario();
        start_load(0, 'h000, 3);
        send_beat(64'hDEAD, 1'b1);
        gap(2);
        check_writes("s5b");
        check("s5b_done", n_done_seen, 1);
        check("s5b_cnt", beat_cnt, 15'd0);
        check("s5b_errs", {err_short, err_long}, 2'b01);

        // 5c: a new ld_start clears the error; depth 0 behaves as 1
        begin_scenario();
        push_exp(4'b0001, 10'h080, 64'h6000);
        push_exp(4'b0010, 10'h080, 64'h6001);
        start_load(2, 'h080, 0);
        check("s5c_clr_errs", {err_short, err_long}, 2'b00);
        check("s5c_clr_cnt", beat_cnt, 15'd0);
        for (int i = 0; i < 2; i++) send_beat(64'h6000 + 64'(i), i == 1);
        gap(2);
        check_writes("s5c");
        check("s5c_done", n_done_seen, 1);
        check("s5c_cnt", beat_cnt, 15'd2);

        // 6: reset after beat 2 of 8, with a third beat on offer
        begin_scenario();
        push_exp(4'b0001, 10'h040, 64'h7000);
        push_exp(4'b0001, 10'h041, 64'h7001);
        start_load(8, 'h040, 4);
        for (int i = 0; i < 2; i++) send_beat(64'h7000 + 64'(i), 1'b0);
        ds_empty_n    = 1'b1;
        fifo_data_din = 64'h7002;
        reset         = 1'b0;
        tick();
        check("s6_rst_read", ds_read, 1'b0);
        check("s6_rst_wen", sram_wen, 4'b0);
        tick();
        reset      = 1'b1;
        ds_empty_n = 1'b0;
        gap(1);
        check_writes("s6");
        check("s6_done", n_done_seen, 0);

        begin_scenario();
        push_exp(4'b0001, 10'h050, 64'h7100);
        push_exp(4'b0001, 10'h051, 64'h7101);
        start_load(2, 'h050, 4);
        for (int i = 0; i < 2; i++) send_beat(64'h7100 + 64'(i), i == 1);
        gap(2);
        check_writes("s6b");
        check("s6b_done", n_done_seen, 1);
        check("s6b_cnt", beat_cnt, 15'd2);
        check("s6b_errs", {err_short, err_long}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
